// File: rtl/pt_pkg.sv
// Shared PT2262-style line definitions: code-bit encoding, word size, decoder FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pt_pkg;

    // Code-bit symbols carried as 2-bit fields in the 24-bit word
    localparam logic [1:0] CB_ZERO  = 2'b00;   // short, short
    localparam logic [1:0] CB_ONE   = 2'b01;   // long,  long
    localparam logic [1:0] CB_FLOAT = 2'b10;   // short, long

    localparam int N_CODEBITS = 12;
    localparam int WORD_W     = 2 * N_CODEBITS;
    localparam int N_PULSES   = 2 * N_CODEBITS;

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RECV  = 2'd2
    } pt_state_e;

    // Map a (first, second) pulse-width pair onto a code bit.
    // The long-short pair has no symbol; callers reject it before using this.
    function automatic logic [1:0] pair_to_cb(input logic first_long, input logic second_long);
        logic [1:0] cb;
        cb = CB_FLOAT;
        if (!first_long && !second_long) begin
            cb = CB_ZERO;
        end else if (first_long && second_long) begin
            cb = CB_ONE;
        end
        return cb;
    endfunction

endpackage

// File: rtl/pt_pulse_meas.sv
// Line front end: 2-FF synchronizer, rise detect, saturating high/low run counters.
// Latency: 2 clk synchronizer, then flags/lengths reflect the line one cycle later.
// Backpressure: none; free-running every clk.
module pt_pulse_meas #(
    parameter int ALPHA    = 4,
    parameter int SYNC_LOW = 64,
    parameter int CW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_rx,
    output logic          o_pulse_done,
    output logic          o_sync_gap,
    output logic          o_stuck_high,
    output logic [CW-1:0] o_h_len,
    output logic [CW-1:0] o_l_len
);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] GAP_LEN  = CW'(SYNC_LOW);
    localparam logic [CW-1:0] STUCK_M1 = CW'(4 * ALPHA - 1);

    logic          r_sync1;
    logic          r_s;
    logic          r_s_d;
    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_l_cnt;
    logic          w_rise;

    assign w_rise = r_s & ~r_s_d;

    // A rise closes the previous pulse: lengths are presented as they stand this cycle
    assign o_pulse_done = w_rise;
    assign o_h_len      = r_h_cnt;
    assign o_l_len      = r_l_cnt;
    // l_cnt sits at GAP_LEN for exactly one cycle: it either keeps counting or a rise clears it
    assign o_sync_gap   = (r_l_cnt == GAP_LEN);
    // Fires in the cycle h_cnt steps onto 4*ALPHA, so it is a single pulse per high run
    assign o_stuck_high = r_s & ~w_rise & (r_h_cnt == STUCK_M1);

    // Synchronize the line and keep saturating run lengths; a rise clears both counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_s     <= 1'b0;
            r_s_d   <= 1'b0;
            r_h_cnt <= '0;
            r_l_cnt <= '0;
        end else begin
            r_sync1 <= i_rx;
            r_s     <= r_sync1;
            r_s_d   <= r_s;
            if (w_rise) begin
                r_h_cnt <= '0;
                r_l_cnt <= '0;
            end else if (r_s) begin
                if (r_h_cnt != CNT_MAX) r_h_cnt <= r_h_cnt + 1'b1;
            end else begin
                if (r_l_cnt != CNT_MAX) r_l_cnt <= r_l_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pt_dec.sv
// PT2272-role decoder: pulse-pair classify, 24-bit word rebuild, sync-gap accept.
// Latency: valid SYNC_LOW+2 clk after the falling edge of the sync pulse.
// Backpressure: none; valid/err are 1-cycle pulses. Build option: PT_DEC_REPEAT_CHECK_EN.
module pt_dec
    import pt_pkg::*;
#(
    parameter int ALPHA    = 4,
    parameter int SYNC_LOW = 64,
    parameter int CW       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    output logic [WORD_W-1:0] data,
    output logic              valid,
    output logic              err,
    output logic              busy
);
    localparam int            PW          = CW + 1;
    localparam logic [CW-1:0] H_SHORT_MIN = CW'(ALPHA / 2);
    localparam logic [CW-1:0] H_LONG_MIN  = CW'(2 * ALPHA);
    localparam logic [CW-1:0] H_LONG_END  = CW'(4 * ALPHA);
    localparam logic [PW-1:0] P_MIN       = PW'(3 * ALPHA);
    localparam logic [PW-1:0] P_MAX       = PW'(5 * ALPHA);
    localparam logic [4:0]    PCNT_FULL   = 5'(N_PULSES);

    logic              w_pulse_done;
    logic              w_sync_gap;
    logic              w_stuck_high;
    logic [CW-1:0]     w_h_len;
    logic [CW-1:0]     w_l_len;
    logic [PW-1:0]     w_period;
    logic              w_h_short;
    logic              w_h_long;
    logic              w_p_ok;

    pt_state_e         r_state;
    pt_state_e         w_state_nxt;
    logic [4:0]        r_pcnt;
    logic [4:0]        w_pcnt_nxt;
    logic              r_first_long;
    logic              w_first_long_nxt;
    logic [WORD_W-1:0] r_shreg;
    logic [WORD_W-1:0] w_shreg_nxt;
    logic              w_accept;
    logic              w_err_nxt;

    pt_pulse_meas #(
        .ALPHA    (ALPHA),
        .SYNC_LOW (SYNC_LOW),
        .CW       (CW)
    ) u_meas (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (rx_in),
        .o_pulse_done (w_pulse_done),
        .o_sync_gap   (w_sync_gap),
        .o_stuck_high (w_stuck_high),
        .o_h_len      (w_h_len),
        .o_l_len      (w_l_len)
    );

    assign w_period  = {1'b0, w_h_len} + {1'b0, w_l_len};
    assign w_h_short = (w_h_len >= H_SHORT_MIN) && (w_h_len < H_LONG_MIN);
    assign w_h_long  = (w_h_len >= H_LONG_MIN)  && (w_h_len < H_LONG_END);
    assign w_p_ok    = (w_period >= P_MIN) && (w_period <= P_MAX);
    assign busy      = (r_state == ST_RECV);

    // State, pulse counter, half-pair memory and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_pcnt       <= '0;
            r_first_long <= 1'b0;
            r_shreg      <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pcnt       <= w_pcnt_nxt;
            r_first_long <= w_first_long_nxt;
            r_shreg      <= w_shreg_nxt;
        end
    end

    // Next state: hunt for a gap, arm, then collect 24 pulses and close on the sync gap.
    // A rise coinciding with a sync gap starts the next frame immediately so no pulse is lost.
    always_comb begin
        w_state_nxt      = r_state;
        w_pcnt_nxt       = r_pcnt;
        w_first_long_nxt = r_first_long;
        w_shreg_nxt      = r_shreg;
        w_accept         = 1'b0;
        w_err_nxt        = 1'b0;
        unique case (r_state)
            ST_HUNT: begin
                if (w_sync_gap) begin
                    w_state_nxt = w_pulse_done ? ST_RECV : ST_ARMED;
                    w_pcnt_nxt  = '0;
                end
            end
            ST_ARMED: begin
                if (w_pulse_done) begin
                    w_state_nxt = ST_RECV;
                    w_pcnt_nxt  = '0;
                end else if (w_stuck_high) begin
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_RECV: begin
                if (w_stuck_high) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_HUNT;
                end else if (w_sync_gap) begin
                    if ((r_pcnt == PCNT_FULL) && w_h_short) begin
                        w_accept = 1'b1;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                    w_state_nxt = w_pulse_done ? ST_RECV : ST_ARMED;
                    w_pcnt_nxt  = '0;
                end else if (w_pulse_done) begin
                    if ((r_pcnt == PCNT_FULL) || !(w_h_short || w_h_long) || !w_p_ok) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end else if (!r_pcnt[0]) begin
                        w_first_long_nxt = w_h_long;
                        w_pcnt_nxt       = r_pcnt + 1'b1;
                    end else if (r_first_long && !w_h_long) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end else begin
                        w_shreg_nxt = {r_shreg[WORD_W-3:0], pair_to_cb(r_first_long, w_h_long)};
                        w_pcnt_nxt  = r_pcnt + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_HUNT;
            end
        endcase
    end

`ifdef PT_DEC_REPEAT_CHECK_EN
    logic [WORD_W-1:0] r_pend;
    logic              r_pend_vld;

    // Publish a word only when it repeats the previous accepted frame; any err forgets it
    always_ff @(posedge clk) begin
        if (rst) begin
            data       <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= w_err_nxt;
            if (w_err_nxt) begin
                r_pend_vld <= 1'b0;
            end else if (w_accept) begin
                if (r_pend_vld && (r_pend == r_shreg)) begin
                    data  <= r_shreg;
                    valid <= 1'b1;
                end else begin
                    r_pend     <= r_shreg;
                    r_pend_vld <= 1'b1;
                end
            end
        end
    end
`else
    // Publish every accepted frame
    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
            err   <= 1'b0;
        end else begin
            valid <= w_accept;
            err   <= w_err_nxt;
            if (w_accept) data <= r_shreg;
        end
    end
`endif

endmodule
